// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone port among Count masters.
// Optional bus watchdog is compiled in with `define WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
   parameter int unsigned Count         = 2,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [Count*DataWidth-1:0]     m_data_m,
   input  logic [Count*AddrWidth-1:0]     m_addr,
   input  logic [Count*(DataWidth/8)-1:0] m_sel,
   input  logic [Count-1:0]               m_cyc,
   input  logic [Count-1:0]               m_stb,
   input  logic [Count-1:0]               m_we,
   output logic [DataWidth-1:0]           m_data_s,
   output logic [Count-1:0]               m_ack,
   output logic [Count-1:0]               m_err,
   output logic [Count-1:0]               m_stall,
   input  logic [DataWidth-1:0]           s_data_s,
   input  logic                           s_ack,
   input  logic                           s_err,
   input  logic                           s_stall,
   output logic [DataWidth-1:0]           s_data_m,
   output logic [AddrWidth-1:0]           s_addr,
   output logic [DataWidth/8-1:0]         s_sel,
   output logic                           s_cyc,
   output logic                           s_stb,
   output logic                           s_we
);

   localparam int unsigned SelWidth = DataWidth / 8;
   localparam int unsigned IdxWidth = (Count > 1) ? $clog2(Count) : 1;

`ifdef WB_ARBITER_TIMEOUT_EN
   typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

   logic [CntWidth-1:0] tmo_q, tmo_d;
   logic                abort_first_q, abort_first_d;
   logic                tmo_hit;

   assign tmo_hit = (tmo_q + CntWidth'(1)) == CntWidth'(TimeoutCycles);
`else
   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TimeoutCycles;
`endif

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] grant_q, grant_d;
   logic [IdxWidth-1:0] last_q, last_d;

   logic                pick_valid;
   logic [IdxWidth-1:0] pick;
   logic [IdxWidth-1:0] scan_idx;

   logic [DataWidth-1:0] gnt_data;
   logic [AddrWidth-1:0] gnt_addr;
   logic [SelWidth-1:0]  gnt_sel;

   // Scan requesters starting just after the last winner so every master gets a turn.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      scan_idx   = '0;
      for (int unsigned k = 1; k <= Count; k++) begin
         scan_idx = IdxWidth'((32'(last_q) + k) % Count);
         if (!pick_valid && m_cyc[scan_idx]) begin
            pick_valid = 1'b1;
            pick       = scan_idx;
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      gnt_addr = '0;
      gnt_sel  = '0;
      for (int unsigned i = 0; i < Count; i++) begin
         if (IdxWidth'(i) == grant_q) begin
            gnt_data = m_data_m[i*DataWidth +: DataWidth];
            gnt_addr = m_addr[i*AddrWidth +: AddrWidth];
            gnt_sel  = m_sel[i*SelWidth +: SelWidth];
         end
      end
   end

   assign m_data_s = s_data_s;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      s_data_m = '0;
      s_addr   = '0;
      s_sel    = '0;
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      m_ack    = '0;
      m_err    = '0;
      m_stall  = '1;
`ifdef WB_ARBITER_TIMEOUT_EN
      tmo_d         = tmo_q;
      abort_first_d = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d = StBusy;
               grant_d = pick;
               last_d  = pick;
`ifdef WB_ARBITER_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         StBusy: begin
            s_data_m         = gnt_data;
            s_addr           = gnt_addr;
            s_sel            = gnt_sel;
            s_cyc            = m_cyc[grant_q];
            s_stb            = m_stb[grant_q];
            s_we             = m_we[grant_q];
            m_ack[grant_q]   = s_ack;
            m_err[grant_q]   = s_err;
            m_stall[grant_q] = s_stall;
            if (!m_cyc[grant_q]) begin
               state_d = StIdle;
            end
`ifdef WB_ARBITER_TIMEOUT_EN
            else if (s_ack || s_err) begin
               tmo_d = '0;
            end else if (tmo_hit) begin
               state_d       = StAbort;
               abort_first_d = 1'b1;
            end else begin
               tmo_d = tmo_q + CntWidth'(1);
            end
`endif
         end
`ifdef WB_ARBITER_TIMEOUT_EN
         StAbort: begin
            // Bus is cut off; the master sees a single error pulse and must drop cyc.
            m_err[grant_q] = abort_first_q;
            if (!m_cyc[grant_q]) begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= IdxWidth'(Count - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef WB_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q         <= '0;
         abort_first_q <= 1'b0;
      end else begin
         tmo_q         <= tmo_d;
         abort_first_q <= abort_first_d;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against an ownership-based reference model.
module tb_wb_arbiter;

   localparam int unsigned Count = 3;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned Tmo   = 8;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [Count*DW-1:0] m_data_m;
   logic [Count*AW-1:0] m_addr;
   logic [Count*SW-1:0] m_sel;
   logic [Count-1:0]    m_cyc, m_stb, m_we;
   logic [DW-1:0]       m_data_s;
   logic [Count-1:0]    m_ack, m_err, m_stall;
   logic [DW-1:0]       s_data_s;
   logic                s_ack, s_err, s_stall;
   logic [DW-1:0]       s_data_m;
   logic [AW-1:0]       s_addr;
   logic [SW-1:0]       s_sel;
   logic                s_cyc, s_stb, s_we;

   always #5 clk = ~clk;

   wb_arbiter #(
      .Count(Count), .DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(Tmo)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m_data_m(m_data_m), .m_addr(m_addr), .m_sel(m_sel),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
      .m_data_s(m_data_s), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
      .s_data_s(s_data_s), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
      .s_data_m(s_data_m), .s_addr(s_addr), .s_sel(s_sel),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: who owns the bus, who won last, watchdog bookkeeping.
   int owner       = -1;
   int last_m      = Count - 1;
   int tmo         = 0;
   bit aborted     = 1'b0;
   bit abort_first = 1'b0;

   always @(posedge clk or negedge reset_n) begin : model
      int j;
      if (!reset_n) begin
         owner       = -1;
         last_m      = Count - 1;
         tmo         = 0;
         aborted     = 1'b0;
         abort_first = 1'b0;
      end else begin
         abort_first = 1'b0;
         if (owner < 0) begin
            for (int k = 1; k <= Count; k++) begin
               j = (last_m + k) % Count;
               if (owner < 0 && m_cyc[j]) begin
                  owner   = j;
                  last_m  = j;
                  tmo     = 0;
                  aborted = 1'b0;
               end
            end
         end else if (!m_cyc[owner]) begin
            owner   = -1;
            aborted = 1'b0;
         end
`ifdef WB_ARBITER_TIMEOUT_EN
         else if (!aborted) begin
            if (s_ack || s_err) tmo = 0;
            else begin
               tmo++;
               if (tmo == Tmo) begin
                  aborted     = 1'b1;
                  abort_first = 1'b1;
               end
            end
         end
`endif
      end
   end

   always @(negedge clk) begin : cmp
      logic [DW-1:0]    e_dm;
      logic [AW-1:0]    e_addr;
      logic [SW-1:0]    e_sel;
      logic             e_cyc, e_stb, e_we;
      logic [Count-1:0] e_ack, e_errv, e_stall;
      e_dm = '0; e_addr = '0; e_sel = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_ack = '0; e_errv = '0; e_stall = '1;
      if (owner >= 0 && !aborted) begin
         e_dm           = m_data_m[owner*DW +: DW];
         e_addr         = m_addr[owner*AW +: AW];
         e_sel          = m_sel[owner*SW +: SW];
         e_cyc          = m_cyc[owner];
         e_stb          = m_stb[owner];
         e_we           = m_we[owner];
         e_ack[owner]   = s_ack;
         e_errv[owner]  = s_err;
         e_stall[owner] = s_stall;
      end else if (owner >= 0) begin
         e_errv[owner] = abort_first;
      end
      chk("cmp_s_cyc", s_cyc, e_cyc);
      chk("cmp_s_stb", s_stb, e_stb);
      chk("cmp_s_we", s_we, e_we);
      chk("cmp_s_addr", s_addr, e_addr);
      chk("cmp_s_data_m", s_data_m, e_dm);
      chk("cmp_s_sel", s_sel, e_sel);
      chk("cmp_m_ack", m_ack, e_ack);
      chk("cmp_m_err", m_err, e_errv);
      chk("cmp_m_stall", m_stall, e_stall);
      chk("cmp_m_data_s", m_data_s, s_data_s);
   end

   initial begin
      int order[$];
      int gaps[$];
      int gap, drop, rer, id;

      reset_n = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '1;
      s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_data_s = '0;
      for (int i = 0; i < Count; i++) begin
         m_addr[i*AW +: AW]   = 32'h1000_0000 * (i + 1);
         m_data_m[i*DW +: DW] = 32'hD000_0000 + i;
      end

      // Reset held with everyone requesting.
      m_cyc = '1; m_stb = '1;
      step(); step();
      chk("rst_s_cyc", s_cyc, 0);
      chk("rst_m_stall", m_stall, 3'b111);
      chk("rst_m_ack", m_ack, 0);
      reset_n = 1'b1;
      #1 chk("rst_idle_stall", m_stall, 3'b111);
      step();
      chk("rst_first_cyc", s_cyc, 1);
      chk("rst_first_addr", s_addr, 32'h1000_0000);
      chk("rst_first_stall", m_stall, 3'b110);
      chk("model_first_owner", owner, 0);

      // Single read by master 1.
      m_cyc = '0; m_stb = '0;
      step();
      m_addr[1*AW +: AW] = 32'h2000_0000;
      m_cyc = 3'b010; m_stb = 3'b010; m_we = '0;
      #1 chk("rd_wait_stall", m_stall[1], 1);
      step();
      chk("rd_s_cyc", s_cyc, 1);
      chk("rd_s_stb", s_stb, 1);
      chk("rd_s_addr", s_addr, 32'h2000_0000);
      step();
      m_stb = '0;
      step();
      s_ack = 1'b1; s_data_s = 32'h5;
      #1 chk("rd_m_ack", m_ack, 3'b010);
      chk("rd_m_data_s", m_data_s, 32'h5);
      step();
      s_ack = 1'b0; m_cyc = '0;
      step();

      // Contention: all request, each does one acked write and briefly drops cyc.
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
      m_cyc = '1; m_stb = '1; m_we = '1; s_ack = 1'b1;
      gap = 0; drop = -1; rer = -1;
      for (int c = 0; c < 30 && order.size() < 4; c++) begin
         step();
         if (rer >= 0) begin
            m_cyc[rer] = 1'b1; m_stb[rer] = 1'b1; rer = -1;
         end
         if (drop >= 0) begin
            m_cyc[drop] = 1'b0; m_stb[drop] = 1'b0; rer = drop; drop = -1;
         end
         #1;
         if (s_cyc) begin
            id = int'(s_addr[31:28]) - 1;
            order.push_back(id);
            gaps.push_back(gap);
            gap  = 0;
            drop = id;
         end else begin
            gap++;
         end
      end
      chk("cont_count", order.size(), 4);
      if (order.size() == 4) begin
         chk("cont_order0", order[0], 0);
         chk("cont_order1", order[1], 1);
         chk("cont_order2", order[2], 2);
         chk("cont_order3", order[3], 0);
         for (int i = 1; i < 4; i++) chk("cont_gap", gaps[i], 2);
      end
      m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
      step(); step();

      // Blocking: master 2 waits behind master 0.
      m_cyc = 3'b001; m_stb = 3'b001;
      step();
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1 chk("blk_stall2", m_stall[2], 1);
         chk("blk_addr", s_addr, 32'h1000_0000);
         step();
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      #1 chk("blk_rel_cyc", s_cyc, 0);
      step();
      chk("blk_idle_stall2", m_stall[2], 1);
      step();
      chk("blk_m2_cyc", s_cyc, 1);
      chk("blk_m2_addr", s_addr, 32'h3000_0000);
      chk("model_blk_owner", owner, 2);

      // Asynchronous reset mid-transfer.
      #1 reset_n = 1'b0;
      #1 chk("arst_s_cyc", s_cyc, 0);
      chk("arst_s_stb", s_stb, 0);
      chk("arst_m_stall", m_stall, 3'b111);
      reset_n = 1'b1;
      m_cyc = '1; m_stb = '1;
      step();
      chk("arst_first_addr", s_addr, 32'h1000_0000);

      // Slave never answers.
      m_cyc = 3'b001; m_stb = 3'b001;
`ifdef WB_ARBITER_TIMEOUT_EN
      for (int c = 0; c <= 12; c++) begin
         #1 chk("tmo_err", m_err, (c == 8) ? 3'b001 : 3'b000);
         chk("tmo_s_cyc", s_cyc, (c < 8) ? 1 : 0);
         step();
      end
      m_cyc = '0; m_stb = '0;
      step(); step();
      chk("tmo_idle_cyc", s_cyc, 0);
      chk("tmo_idle_stall", m_stall, 3'b111);
`else
      repeat (100) step();
      chk("notmo_busy", s_cyc, 1);
      chk("notmo_err", m_err, 0);
      m_cyc = '0; m_stb = '0;
`endif
      step(); step();

      // Random traffic, including occasional resets.
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(199) == 0) reset_n = 1'b0;
         for (int i = 0; i < Count; i++) begin
            if (m_cyc[i]) begin
               if ($urandom_range(5) == 0) m_cyc[i] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               m_cyc[i] = 1'b1;
            end
         end
         m_stb    = Count'($urandom());
         m_we     = Count'($urandom());
         m_sel    = (Count*SW)'($urandom());
         m_addr   = {$urandom(), $urandom(), $urandom()};
         m_data_m = {$urandom(), $urandom(), $urandom()};
         s_ack    = 1'($urandom_range(1));
         s_err    = ($urandom_range(7) == 0);
         s_stall  = 1'($urandom_range(1));
         s_data_s = $urandom();
      end
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
